// File: rtl/wb_result_arbiter_if.sv
// Writeback result arbiter bus bundle.
//   src_valid/src_ready/src_data/src_rd : per-source result handshake (flattened
//                                          vectors, source i at [i*W +: W])
//   wb_valid/wb_ready                   : registered writeback handshake
//   wb_data/wb_rd/wb_we/wb_src          : writeback payload, write enable, winner
// Modports: slave = arbiter side, master = producer/consumer (bench) side.
interface wb_result_arbiter_if #(
  parameter int NUM_SRC = 7,
  parameter int DATA_W  = 32,
  parameter int RD_W    = 5
);
  localparam int SRC_W = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC-1:0]        src_ready;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [NUM_SRC*RD_W-1:0]   src_rd;
  logic                      wb_valid;
  logic                      wb_ready;
  logic [DATA_W-1:0]         wb_data;
  logic [RD_W-1:0]           wb_rd;
  logic                      wb_we;
  logic [SRC_W-1:0]          wb_src;

  modport slave (
    input  src_valid, src_data, src_rd, wb_ready,
    output src_ready, wb_valid, wb_data, wb_rd, wb_we, wb_src
  );

  modport master (
    output src_valid, src_data, src_rd, wb_ready,
    input  src_ready, wb_valid, wb_data, wb_rd, wb_we, wb_src
  );
endinterface

// File: rtl/wb_result_arbiter.sv
// wb_result_arbiter: writeback collector for NUM_SRC execution units.
// Each source owns a one-entry holding slot; one full slot per cycle is granted
// onto a registered writeback port with back-pressure (wb_ready).
// Ports:
//   clk   : clock, all state on rising edge
//   rst   : synchronous active-high reset
//   flush : synchronous flush, drops every buffered and pending result
//   bus   : wb_result_arbiter_if.slave (source handshakes + writeback port)
// Config macro WB_RR_ARB_EN: defined -> round-robin arbitration,
//   undefined -> fixed priority, lowest source index wins.

// One holding slot: {full, data, rd}.
module wb_result_slot #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,    // flush: drop contents
  input  logic              load_i,   // source handshake this cycle
  input  logic              drain_i,  // slot granted this cycle
  input  logic [DATA_W-1:0] data_i,
  input  logic [RD_W-1:0]   rd_i,
  output logic              full_o,
  output logic [DATA_W-1:0] data_o,
  output logic [RD_W-1:0]   rd_o
);
  logic              full_q, full_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [RD_W-1:0]   rd_q, rd_d;

  // Load takes precedence over drain so a same-cycle drain+refill stays full.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    rd_d   = rd_q;
    if (drain_i) full_d = 1'b0;
    if (load_i) begin
      full_d = 1'b1;
      data_d = data_i;
      rd_d   = rd_i;
    end
    if (clr_i) full_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
      rd_q   <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      rd_q   <= rd_d;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;
  assign rd_o   = rd_q;
endmodule

module wb_result_arbiter #(
  parameter int NUM_SRC = 7,
  parameter int DATA_W  = 32,
  parameter int RD_W    = 5
) (
  input logic                clk,
  input logic                rst,
  input logic                flush,
  wb_result_arbiter_if.slave bus
);
  localparam int SRC_W = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0]             full;
  logic [NUM_SRC-1:0]             grant;
  logic [NUM_SRC-1:0]             src_ready;
  logic [NUM_SRC-1:0]             accept;
  logic [NUM_SRC-1:0][DATA_W-1:0] slot_data;
  logic [NUM_SRC-1:0][RD_W-1:0]   slot_rd;
  logic [SRC_W-1:0]               win;
  logic                           any;
  logic                           adv;

  logic              wb_valid_q, wb_valid_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [RD_W-1:0]   wb_rd_q, wb_rd_d;
  logic [SRC_W-1:0]  wb_src_q, wb_src_d;
`ifdef WB_RR_ARB_EN
  logic [SRC_W-1:0]  ptr_q, ptr_d;
`endif

  assign adv = ~wb_valid_q | bus.wb_ready;

  // Ready never looks at src_valid; it is killed during rst/flush so nothing
  // is accepted into a slot that is being cleared.
  assign src_ready     = (~full | grant) & {NUM_SRC{~(rst | flush)}};
  assign accept        = bus.src_valid & src_ready;
  assign bus.src_ready = src_ready;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_slot
    wb_result_slot #(.DATA_W(DATA_W), .RD_W(RD_W)) u_slot (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (flush),
      .load_i  (accept[g]),
      .drain_i (grant[g]),
      .data_i  (bus.src_data[g*DATA_W +: DATA_W]),
      .rd_i    (bus.src_rd[g*RD_W +: RD_W]),
      .full_o  (full[g]),
      .data_o  (slot_data[g]),
      .rd_o    (slot_rd[g])
    );
  end

  // Pick one full slot; the grant is only issued when the output can take it.
  always_comb begin
`ifdef WB_RR_ARB_EN
    int j;
`endif
    grant = '0;
    win   = '0;
    any   = 1'b0;
`ifdef WB_RR_ARB_EN
    // Scan starting at the pointer, wrapping past NUM_SRC-1.
    for (int k = 0; k < NUM_SRC; k++) begin
      j = int'(ptr_q) + k;
      if (j >= NUM_SRC) j = j - NUM_SRC;
      if (!any && full[j]) begin
        any = 1'b1;
        win = SRC_W'(j);
      end
    end
`else
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!any && full[i]) begin
        any = 1'b1;
        win = SRC_W'(i);
      end
    end
`endif
    if (!adv || rst || flush) any = 1'b0;
    if (any) grant[win] = 1'b1;
  end

  always_comb begin
    wb_valid_d = wb_valid_q;
    wb_data_d  = wb_data_q;
    wb_rd_d    = wb_rd_q;
    wb_src_d   = wb_src_q;
    if (flush) begin
      wb_valid_d = 1'b0;
    end else if (adv) begin
      wb_valid_d = any;
      if (any) begin
        wb_data_d = slot_data[win];
        wb_rd_d   = slot_rd[win];
        wb_src_d  = win;
      end
    end
  end

`ifdef WB_RR_ARB_EN
  // Winner drops to lowest priority; flush leaves the pointer alone.
  always_comb begin
    ptr_d = ptr_q;
    if (any) ptr_d = (win == SRC_W'(NUM_SRC - 1)) ? '0 : SRC_W'(win + 1'b1);
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
      wb_src_q   <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_rd_q    <= wb_rd_d;
      wb_src_q   <= wb_src_d;
    end
  end

  assign bus.wb_valid = wb_valid_q;
  assign bus.wb_data  = wb_data_q;
  assign bus.wb_rd    = wb_rd_q;
  assign bus.wb_src   = wb_src_q;
  assign bus.wb_we    = wb_valid_q & (wb_rd_q != '0);
endmodule
